apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB requester (initiator) that drives the slaves on the 8-bit APB bus.
- Accepts single read/write commands from a local valid/ready command port.
- Sequences each command through the APB SETUP and ACCESS phases, waiting on pready.
- Returns read data and status on a valid/ready response port; one transfer outstanding at a time.

Parameters:
ADDR_W, 8, width of paddr and cmd_addr
DATA_W, 8, width of pwdata/prdata and command/response data
TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only when APB_TIMEOUT_EN is defined

Ports:
pclk  input  1  clock; all state updates on the rising edge
preset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  transfer address
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  output  DATA_W  read data (0 for writes)
rsp_timeout  output  1  transfer aborted by timeout (always 0 without APB_TIMEOUT_EN)
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_W  APB address
pwdata  output  DATA_W  APB write data
prdata  input  DATA_W  APB read data
pready  input  1  APB ready

Behaviour:
- Reset (preset low, asynchronous): all of the following go to 0 immediately, regardless of clock: state IDLE, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_timeout, timeout counter.
- Reset mid-transfer: the bus is released at once and the in-flight command and any pending response are discarded.
- cmd_ready = (state == IDLE) && !rsp_valid. This is combinational from registered state; it is 0 while any response is pending.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE -> SETUP on cmd accept:
  - The accepted cmd_write, cmd_addr and cmd_wdata are registered onto pwrite, paddr and pwdata.
  - pwdata is forced to 0 for reads.
  - psel = 1, penable = 0.
- SETUP -> ACCESS unconditionally after one cycle: psel = 1, penable = 1.
- ACCESS with pready = 0: stay in ACCESS. psel, penable, pwrite, paddr and pwdata hold stable.
- ACCESS with pready = 1 (sampled at the clock edge):
  - Next state is IDLE; psel and penable go to 0.
  - rsp_valid goes to 1.
  - rsp_rdata captures prdata for reads, or 0 for writes.
  - rsp_timeout = 0.
- paddr, pwrite and pwdata may hold their last values in IDLE; only psel qualifies them.
- Latency:
  - Cmd accepted at edge T. SETUP occupies cycle T..T+1 and ACCESS begins at T+1.
  - With zero-wait pready, rsp_valid is asserted after edge T+2.
  - Each pready-low ACCESS cycle adds one cycle.
- Response handshake:
  - rsp_valid and rsp_rdata are held until rsp_valid && rsp_ready; rsp_valid clears on that edge.
  - The earliest next cmd accept is the cycle after the response is consumed.
- There are no back-to-back transfers without IDLE, and no pipelining.
- pready outside ACCESS is ignored. prdata is sampled only on the completing ACCESS edge.
- cmd_valid while cmd_ready = 0 is ignored. The requester must hold the command.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready = 0.
  - When the count reaches TIMEOUT_CYCLES-1 and pready is still 0, the FSM returns to IDLE and psel and penable drop.
  - rsp_valid = 1, rsp_timeout = 1, rsp_rdata = 0.
  - If pready = 1 on that same cycle, normal completion wins and rsp_timeout = 0.
- Not defined: there is no counter, ACCESS waits indefinitely, and rsp_timeout is tied to 0.

Decomposition:
- Package apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS);
  - APB_ADDR_W = 8 and APB_DATA_W = 8 default constants;
  - TIMEOUT_CYCLES_DEFAULT = 16.
- Sub-module apb_wait_timer:
  - counter with clear, enable and expire outputs;
  - instantiated only under APB_TIMEOUT_EN.
- FSM and registers stay in apb_master.

Test Plan:
1. Write, zero-wait slave: cmd write addr 0x10 data 0xA5.
   - Required: psel=1 penable=0 for one cycle, then psel=1 penable=1 pwrite=1 paddr=0x10 pwdata=0xA5.
   - Required: rsp_valid asserted 2 cycles after accept, rsp_rdata = 0.
2. Read back: cmd read addr 0x10, slave returns 0xA5.
   - Required: pwrite=0, pwdata=0, rsp_rdata=0xA5.
   - Required: cmd_ready=0 until the response is consumed.
3. Wait states: slave holds pready=0 for 3 ACCESS cycles on a write addr 0x3C data 0x5A.
   - Required: psel, penable, paddr and pwdata stable for 4 ACCESS cycles.
   - Required: response 5 cycles after accept.
4. Response backpressure: rsp_ready=0 for 4 cycles after a read of addr 0x01.
   - Required: rsp_valid and rsp_rdata held, cmd_ready=0, new cmd_valid ignored.
   - Required: accept occurs the cycle after rsp_ready=1.
5. Async reset in ACCESS: drop preset mid-cycle with pready=0.
   - Required: psel, penable and rsp_valid go to 0 without waiting for a clock edge.
   - Required: after release, cmd_ready=1 and the next command completes normally.
6. APB_TIMEOUT_EN with TIMEOUT_CYCLES=16: pready held at 0.
   - Required: bus released after 16 ACCESS cycles, rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
   - Repeat with pready=1 on the 16th cycle: required rsp_timeout=0 and read data returned.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB requester slice.
package apb_pkg;

   localparam int APB_ADDR_W             = 8;
   localparam int APB_DATA_W             = 8;
   localparam int TIMEOUT_CYCLES_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: cleared on entry, counts stalled cycles and
// flags expiry once LIMIT-1 stalled cycles have been seen.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign expire = (count_q == CNT_W'(LIMIT - 1));

   // Saturates at the expiry value so a missed exit can never wrap to zero.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expire) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time through SETUP/ACCESS, response on a
// valid/ready port. Define APB_TIMEOUT_EN to bound the ACCESS wait.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   apb_state_e        state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_timeout_q, rsp_timeout_d;

   logic cmd_fire;
   logic rsp_fire;
   logic timeout_hit;

   assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign rsp_fire  = rsp_valid_q && rsp_ready;

`ifdef APB_TIMEOUT_EN
   logic timer_expire;

   apb_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk    (pclk),
      .rst_n  (preset),
      .clear  (state_q == SETUP),
      .enable ((state_q == ACCESS) && !pready),
      .expire (timer_expire)
   );

   assign timeout_hit = (state_q == ACCESS) && !pready && timer_expire;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout_hit        = 1'b0;
`endif

   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_timeout = rsp_timeout_q;

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cmd_fire) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (pready || timeout_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Normal completion is tested before the timeout so a late pready still wins.
   always_comb begin
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_timeout_d = rsp_timeout_q;

      if (rsp_fire) begin
         rsp_valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = cmd_write;
               paddr_d   = cmd_addr;
               pwdata_d  = cmd_write ? cmd_wdata : '0;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (pready) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = pwrite_q ? '0 : prdata;
               rsp_timeout_d = 1'b0;
            end else if (timeout_hit) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_timeout_d = 1'b1;
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master with a small memory-backed APB slave.
// Build with APB_TIMEOUT_EN defined to include the timeout scenario.
module tb_apb_master;

   logic       pclk;
   logic       preset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_rdata;
   logic       rsp_timeout;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;

   typedef struct {
      logic [7:0] rdata;
      logic       timeout;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_e;
   int   n_checks;
   int   n_fail;

   logic [7:0] slave_mem [256];

   apb_master #(
      .ADDR_W         (8),
      .DATA_W         (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .pclk        (pclk),
      .preset      (preset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_timeout (rsp_timeout),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   assign prdata = slave_mem[paddr];

   always @(posedge pclk) begin
      if (psel && penable && pready && pwrite) slave_mem[paddr] <= pwdata;
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] rdata, input logic timeout);
      exp_t e;
      e.rdata   = rdata;
      e.timeout = timeout;
      exp_q.push_back(e);
   endtask

   // Presents a command, waits (bounded) for cmd_ready, returns just after the accepting edge.
   task automatic issue_cmd(input logic w, input logic [7:0] a, input logic [7:0] d, output bit ok);
      int n;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      ok = (cmd_ready === 1'b1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int max, output int cycles);
      cycles = 0;
      while (rsp_valid !== 1'b1 && cycles < max) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (psel !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_psel: got %b want 0", psel); end
      n_checks++; if (penable !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_penable: got %b want 0", penable); end
      n_checks++; if (pwrite !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_pwrite: got %b want 0", pwrite); end
      n_checks++; if (paddr !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_paddr: got %h want 00", paddr); end
      n_checks++; if (pwdata !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_pwdata: got %h want 00", pwdata); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      n_checks++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_rsp_rdata: got %h want 00", rsp_rdata); end
      n_checks++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rsp_timeout: got %b want 0", rsp_timeout); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
      tick();
      tick();
      preset = 1'b1;
      tick();
      n_checks++; if (psel !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_release_psel: got %b want 0", psel); end
   endtask

   task automatic test_write();
      bit ok;
      pready    = 1'b1;
      rsp_ready = 1'b0;
      issue_cmd(1'b1, 8'h10, 8'hA5, ok);
      push_exp(8'h00, 1'b0);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_accept: got %b want 1", ok); end
      n_checks++; if (psel !== 1'b1 || penable !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_setup: got psel=%b penable=%b want 1/0", psel, penable); end
      tick();
      n_checks++; if (psel !== 1'b1 || penable !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_access: got psel=%b penable=%b want 1/1", psel, penable); end
      n_checks++; if (pwrite !== 1'b1 || paddr !== 8'h10 || pwdata !== 8'hA5) begin n_fail++; $display("[TB] FAIL wr_bus: got pwrite=%b paddr=%h pwdata=%h want 1/10/a5", pwrite, paddr, pwdata); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_early_rsp: got %b want 0", rsp_valid); end
      tick();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_rsp_latency: got rsp_valid=%b want 1", rsp_valid); end
      n_checks++; if (psel !== 1'b0 || penable !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_release: got psel=%b penable=%b want 0/0", psel, penable); end
      exp_e = exp_q.pop_front();
      n_checks++; if (rsp_rdata !== exp_e.rdata) begin n_fail++; $display("[TB] FAIL wr_rdata: got %h want %h", rsp_rdata, exp_e.rdata); end
      n_checks++; if (rsp_timeout !== exp_e.timeout) begin n_fail++; $display("[TB] FAIL wr_timeout: got %b want %b", rsp_timeout, exp_e.timeout); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_consume: got %b want 0", rsp_valid); end
   endtask

   task automatic test_read();
      bit ok;
      pready    = 1'b1;
      rsp_ready = 1'b0;
      issue_cmd(1'b0, 8'h10, 8'hFF, ok);
      push_exp(8'hA5, 1'b0);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_accept: got %b want 1", ok); end
      tick();
      n_checks++; if (pwrite !== 1'b0 || pwdata !== 8'h00 || paddr !== 8'h10) begin n_fail++; $display("[TB] FAIL rd_bus: got pwrite=%b pwdata=%h paddr=%h want 0/00/10", pwrite, pwdata, paddr); end
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_busy_ready: got %b want 0", cmd_ready); end
      tick();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_rsp_latency: got %b want 1", rsp_valid); end
      exp_e = exp_q.pop_front();
      n_checks++; if (rsp_rdata !== exp_e.rdata) begin n_fail++; $display("[TB] FAIL rd_rdata: got %h want %h", rsp_rdata, exp_e.rdata); end
      n_checks++; if (rsp_timeout !== exp_e.timeout) begin n_fail++; $display("[TB] FAIL rd_timeout: got %b want %b", rsp_timeout, exp_e.timeout); end
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_pending_ready: got %b want 0", cmd_ready); end
      tick();
      n_checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_hold: got rsp_valid=%b cmd_ready=%b want 1/0", rsp_valid, cmd_ready); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_consume: got rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready); end
   endtask

   task automatic test_wait_states();
      bit ok;
      int lat;
      pready    = 1'b0;
      rsp_ready = 1'b0;
      issue_cmd(1'b1, 8'h3C, 8'h5A, ok);
      push_exp(8'h00, 1'b0);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL ws_accept: got %b want 1", ok); end
      tick();
      lat = 1;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 8'h3C || pwdata !== 8'h5A || pwrite !== 1'b1) begin
            n_fail++; $display("[TB] FAIL ws_stable_%0d: got psel=%b penable=%b paddr=%h pwdata=%h pwrite=%b want 1/1/3c/5a/1", i, psel, penable, paddr, pwdata, pwrite);
         end
         n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ws_early_rsp_%0d: got %b want 0", i, rsp_valid); end
         pready = (i == 3);
         tick();
         lat++;
      end
      pready = 1'b0;
      n_checks++; if (rsp_valid !== 1'b1 || lat != 5) begin n_fail++; $display("[TB] FAIL ws_latency: got rsp_valid=%b after %0d cycles want 1 after 5", rsp_valid, lat); end
      exp_e = exp_q.pop_front();
      n_checks++; if (rsp_rdata !== exp_e.rdata || rsp_timeout !== exp_e.timeout) begin n_fail++; $display("[TB] FAIL ws_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_timeout, exp_e.rdata, exp_e.timeout); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bit ok;
      int cyc;
      pready    = 1'b1;
      rsp_ready = 1'b0;
      issue_cmd(1'b0, 8'h01, 8'h00, ok);
      push_exp(8'h3E, 1'b0);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_accept: got %b want 1", ok); end
      wait_rsp(20, cyc);
      n_checks++; if (rsp_valid !== 1'b1 || cyc != 2) begin n_fail++; $display("[TB] FAIL bp_latency: got rsp_valid=%b after %0d cycles want 1 after 2", rsp_valid, cyc); end
      exp_e     = exp_q.pop_front();
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 8'h22;
      cmd_wdata = 8'h77;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_e.rdata) begin n_fail++; $display("[TB] FAIL bp_hold_%0d: got rsp_valid=%b rdata=%h want 1/%h", i, rsp_valid, rsp_rdata, exp_e.rdata); end
         n_checks++; if (cmd_ready !== 1'b0 || psel !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ignore_%0d: got cmd_ready=%b psel=%b want 0/0", i, cmd_ready, psel); end
         tick();
      end
      n_checks++; if (rsp_timeout !== exp_e.timeout) begin n_fail++; $display("[TB] FAIL bp_timeout: got %b want %b", rsp_timeout, exp_e.timeout); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || psel !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_consume: got rsp_valid=%b cmd_ready=%b psel=%b want 0/1/0", rsp_valid, cmd_ready, psel); end
      tick();
      cmd_valid = 1'b0;
      push_exp(8'h00, 1'b0);
      n_checks++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 8'h22 || pwdata !== 8'h77) begin n_fail++; $display("[TB] FAIL bp_next_accept: got psel=%b penable=%b paddr=%h pwdata=%h want 1/0/22/77", psel, penable, paddr, pwdata); end
      wait_rsp(20, cyc);
      n_checks++; if (rsp_valid !== 1'b1 || cyc != 2) begin n_fail++; $display("[TB] FAIL bp_next_latency: got rsp_valid=%b after %0d cycles want 1 after 2", rsp_valid, cyc); end
      exp_e = exp_q.pop_front();
      n_checks++; if (rsp_rdata !== exp_e.rdata || rsp_timeout !== exp_e.timeout) begin n_fail++; $display("[TB] FAIL bp_next_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_timeout, exp_e.rdata, exp_e.timeout); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      bit ok;
      int cyc;
      pready    = 1'b0;
      rsp_ready = 1'b0;
      issue_cmd(1'b1, 8'h55, 8'h99, ok);
      push_exp(8'h00, 1'b0);
      tick();
      tick();
      n_checks++; if (psel !== 1'b1 || penable !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_in_access: got psel=%b penable=%b want 1/1", psel, penable); end
      #2;
      preset = 1'b0;
      #1;
      n_checks++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_async_clear: got psel=%b penable=%b rsp_valid=%b want 0/0/0", psel, penable, rsp_valid); end
      n_checks++; if (paddr !== 8'h00 || pwdata !== 8'h00 || pwrite !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_bus_clear: got paddr=%h pwdata=%h pwrite=%b want 00/00/0", paddr, pwdata, pwrite); end
      exp_q.delete();
      tick();
      tick();
      preset = 1'b1;
      pready = 1'b1;
      n_checks++; if (cmd_ready !== 1'b1 || psel !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_release: got cmd_ready=%b psel=%b want 1/0", cmd_ready, psel); end
      issue_cmd(1'b0, 8'h10, 8'h00, ok);
      push_exp(8'hA5, 1'b0);
      wait_rsp(20, cyc);
      n_checks++; if (rsp_valid !== 1'b1 || cyc != 2) begin n_fail++; $display("[TB] FAIL ar_next_latency: got rsp_valid=%b after %0d cycles want 1 after 2", rsp_valid, cyc); end
      exp_e = exp_q.pop_front();
      n_checks++; if (rsp_rdata !== exp_e.rdata || rsp_timeout !== exp_e.timeout) begin n_fail++; $display("[TB] FAIL ar_next_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_timeout, exp_e.rdata, exp_e.timeout); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      for (int run = 0; run < 2; run++) begin
         pready    = 1'b0;
         rsp_ready = 1'b0;
         issue_cmd(1'b0, 8'h10, 8'h00, ok);
         if (run == 0) push_exp(8'h00, 1'b1);
         else          push_exp(8'hA5, 1'b0);
         tick();
         for (int i = 0; i < 16; i++) begin
            n_checks++; if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL to_wait_r%0d_c%0d: got psel=%b penable=%b rsp_valid=%b want 1/1/0", run, i, psel, penable, rsp_valid); end
            pready = (run == 1) && (i == 15);
            tick();
         end
         pready = 1'b0;
         n_checks++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL to_release_r%0d: got psel=%b penable=%b rsp_valid=%b want 0/0/1", run, psel, penable, rsp_valid); end
         exp_e = exp_q.pop_front();
         n_checks++; if (rsp_rdata !== exp_e.rdata || rsp_timeout !== exp_e.timeout) begin n_fail++; $display("[TB] FAIL to_rsp_r%0d: got %h/%b want %h/%b", run, rsp_rdata, rsp_timeout, exp_e.rdata, exp_e.timeout); end
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
   endtask
`endif

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      preset    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 8'h00;
      cmd_wdata = 8'h00;
      rsp_ready = 1'b0;
      pready    = 1'b0;
      for (int i = 0; i < 256; i++) slave_mem[i] = 8'h00;
      slave_mem[8'h01] = 8'h3E;
      #3;
      preset = 1'b0;

      test_reset();
      test_write();
      test_read();
      test_wait_states();
      test_backpressure();
      test_async_reset();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif

      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
